// File: rtl/buffet_core.sv
// Buffet storage: a circular fill buffer with random-access reads relative to the oldest entry,
// shrink-based release, a single read-for-update lock and batched credit return.
module buffet_core #(
  parameter int DATA_WIDTH   = 32,
  parameter int IDX_WIDTH    = 4,
  parameter int CREDIT_BATCH = 4
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [IDX_WIDTH-1:0]  read_idx_i,
  input  logic                  read_will_update_i,
  input  logic                  read_is_shrink_i,
  input  logic                  read_valid_i,
  output logic                  read_ready_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  read_data_valid_o,
  input  logic                  read_data_ready_i,
  input  logic [IDX_WIDTH-1:0]  update_idx_i,
  input  logic [DATA_WIDTH-1:0] update_data_i,
  input  logic                  update_valid_i,
  output logic                  update_ready_o,
  output logic [IDX_WIDTH:0]    credit_o,
  output logic                  credit_valid_o,
  input  logic                  credit_ready_i,
  output logic [IDX_WIDTH:0]    occupancy_o,
  output logic                  err_o
);

  localparam int DEPTH = 1 << IDX_WIDTH;
  localparam logic [IDX_WIDTH:0] DEPTH_C = (IDX_WIDTH+1)'(DEPTH);
  localparam logic [IDX_WIDTH:0] BATCH_C = (IDX_WIDTH+1)'(CREDIT_BATCH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_WIDTH-1:0]  head, tail, lock_idx;
  logic [IDX_WIDTH-1:0]  rd_addr, up_addr;
  logic [IDX_WIDTH:0]    occupancy, accum, idx_ext, shrink_size;
  logic                  lock_valid, rdata_valid, err;
  logic                  out_free, read_ok, shrink_ok;
  logic                  push_acc, read_acc, shrink_acc, update_acc, credit_hs;

  assign idx_ext  = {1'b0, read_idx_i};
  assign rd_addr  = head + read_idx_i;
  assign up_addr  = head + update_idx_i;
  assign out_free = !rdata_valid || read_data_ready_i;

  // A read may not touch the locked entry, nor take a second lock while one is held.
  assign read_ok = (idx_ext < occupancy)
                && !(lock_valid && (read_idx_i == lock_idx))
                && !(read_will_update_i && lock_valid)
                && out_free;
  assign shrink_ok = !lock_valid && (idx_ext <= occupancy);

  assign push_ready_o   = (occupancy < DEPTH_C);
  assign read_ready_o   = read_is_shrink_i ? shrink_ok : read_ok;
  assign update_ready_o = lock_valid;

  assign push_acc    = push_valid_i && push_ready_o;
  assign read_acc    = read_valid_i && !read_is_shrink_i && read_ok;
  assign shrink_acc  = read_valid_i && read_is_shrink_i && shrink_ok;
  assign update_acc  = update_valid_i && lock_valid;
  assign shrink_size = shrink_acc ? idx_ext : '0;

  assign credit_valid_o = (accum >= BATCH_C) || ((accum != '0) && (occupancy == '0));
  assign credit_hs      = credit_valid_o && credit_ready_i;
  assign credit_o       = accum;

  assign occupancy_o       = occupancy;
  assign read_data_valid_o = rdata_valid;
  assign err_o             = err;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      head        <= '0;
      tail        <= '0;
      occupancy   <= '0;
      accum       <= DEPTH_C;
      lock_valid  <= 1'b0;
      lock_idx    <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (push_acc)   tail <= tail + 1'b1;
      if (shrink_acc) head <= head + read_idx_i;
      occupancy <= occupancy + (IDX_WIDTH+1)'(push_acc) - shrink_size;
      // A shrink landing on a credit beat seeds the next accumulation instead of being lost.
      accum <= credit_hs ? shrink_size : accum + shrink_size;

      if (read_acc)               rdata_valid <= 1'b1;
      else if (read_data_ready_i) rdata_valid <= 1'b0;

      if (update_acc) begin
        lock_valid <= 1'b0;
        if (update_idx_i != lock_idx) err <= 1'b1;
      end
      if (read_acc && read_will_update_i) begin
        lock_valid <= 1'b1;
        lock_idx   <= read_idx_i;
      end
    end
  end

  // Storage and response data carry no reset.
  always_ff @(posedge clk) begin
    if (read_acc)   read_data_o   <= mem[rd_addr];
    if (push_acc)   mem[tail]     <= push_data_i;
    if (update_acc) mem[up_addr]  <= update_data_i;
  end

endmodule

// File: tb/tb_buffet_core.sv
// Directed and randomized checks of buffet_core against a queue-based reference model.
module tb_buffet_core;
  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 16;
  localparam int BATCH = 4;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [DW-1:0] push_data_i;
  logic          push_valid_i, push_ready_o;
  logic [IW-1:0] read_idx_i;
  logic          read_will_update_i, read_is_shrink_i, read_valid_i, read_ready_o;
  logic [DW-1:0] read_data_o;
  logic          read_data_valid_o, read_data_ready_i;
  logic [IW-1:0] update_idx_i;
  logic [DW-1:0] update_data_i;
  logic          update_valid_i, update_ready_o;
  logic [IW:0]   credit_o;
  logic          credit_valid_o, credit_ready_i;
  logic [IW:0]   occupancy_o;
  logic          err_o;

  always #5 clk = ~clk;

  buffet_core #(.DATA_WIDTH(DW), .IDX_WIDTH(IW), .CREDIT_BATCH(BATCH)) dut (
    .clk(clk), .reset_i(reset_i),
    .push_data_i(push_data_i), .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .read_idx_i(read_idx_i), .read_will_update_i(read_will_update_i),
    .read_is_shrink_i(read_is_shrink_i), .read_valid_i(read_valid_i), .read_ready_o(read_ready_o),
    .read_data_o(read_data_o), .read_data_valid_o(read_data_valid_o),
    .read_data_ready_i(read_data_ready_i),
    .update_idx_i(update_idx_i), .update_data_i(update_data_i),
    .update_valid_i(update_valid_i), .update_ready_o(update_ready_o),
    .credit_o(credit_o), .credit_valid_o(credit_valid_o), .credit_ready_i(credit_ready_i),
    .occupancy_o(occupancy_o), .err_o(err_o)
  );

  int total = 0;
  int fails = 0;
  bit cr_default = 1'b1;

  // Reference model: live entries oldest-first, plus lock, credit, error and response state.
  logic [DW-1:0] q[$];
  bit            m_lv, m_err, m_rv;
  int            m_li, m_acc;
  logic [DW-1:0] m_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset_i = 1'b0; push_valid_i = 1'b0; push_data_i = '0;
    read_valid_i = 1'b0; read_idx_i = '0; read_will_update_i = 1'b0; read_is_shrink_i = 1'b0;
    read_data_ready_i = 1'b1; update_valid_i = 1'b0; update_idx_i = '0; update_data_i = '0;
    credit_ready_i = cr_default;
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic tick();
    int occ, sz;
    bit out_free, rd_ok, sh_ok, exp_cv, a_push, a_read, a_shrink, a_upd, a_hs;
    #1;
    occ      = q.size();
    out_free = !m_rv || read_data_ready_i;
    rd_ok    = (int'(read_idx_i) < occ) && !(m_lv && int'(read_idx_i) == m_li)
               && !(read_will_update_i && m_lv) && out_free;
    sh_ok    = !m_lv && (int'(read_idx_i) <= occ);
    exp_cv   = (m_acc >= BATCH) || (m_acc != 0 && occ == 0);
    if (!reset_i) begin
      chk("push_ready", push_ready_o, occ < DEPTH);
      chk("read_ready", read_ready_o, read_is_shrink_i ? sh_ok : rd_ok);
      chk("update_ready", update_ready_o, m_lv);
      chk("credit_valid", credit_valid_o, exp_cv);
      chk("credit", credit_o, m_acc);
      chk("occupancy", occupancy_o, occ);
      chk("err", err_o, m_err);
      chk("rdata_valid", read_data_valid_o, m_rv);
      if (m_rv) chk("rdata", read_data_o, m_rd);
    end
    a_push   = push_valid_i && occ < DEPTH;
    a_read   = read_valid_i && !read_is_shrink_i && rd_ok;
    a_shrink = read_valid_i && read_is_shrink_i && sh_ok;
    a_upd    = update_valid_i && m_lv;
    a_hs     = exp_cv && credit_ready_i;
    sz       = a_shrink ? int'(read_idx_i) : 0;
    @(posedge clk);
    if (reset_i) begin
      q.delete(); m_lv = 0; m_err = 0; m_rv = 0; m_acc = DEPTH; m_li = 0;
    end else begin
      if (a_read) begin m_rv = 1; m_rd = q[read_idx_i]; end
      else if (read_data_ready_i) m_rv = 0;
      if (a_upd) begin
        if (int'(update_idx_i) < q.size()) q[update_idx_i] = update_data_i;
        if (int'(update_idx_i) != m_li) m_err = 1;
        m_lv = 0;
      end
      if (a_read && read_will_update_i) begin m_lv = 1; m_li = int'(read_idx_i); end
      for (int i = 0; i < sz; i++) void'(q.pop_front());
      if (a_push) q.push_back(push_data_i);
      m_acc = a_hs ? sz : m_acc + sz;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); reset_i = 1'b1; tick(); idle();
  endtask
  task automatic push(input logic [DW-1:0] d);
    idle(); push_valid_i = 1'b1; push_data_i = d; tick();
  endtask
  task automatic read(input int idx, input bit wu);
    idle(); read_valid_i = 1'b1; read_idx_i = IW'(idx); read_will_update_i = wu; tick();
  endtask
  task automatic shrink(input int n);
    idle(); read_valid_i = 1'b1; read_is_shrink_i = 1'b1; read_idx_i = IW'(n); tick();
  endtask
  task automatic update(input int idx, input logic [DW-1:0] d);
    idle(); update_valid_i = 1'b1; update_idx_i = IW'(idx); update_data_i = d; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_credit_valid", credit_valid_o, 1);
    chk("rst_credit", credit_o, DEPTH);
    chk("rst_occupancy", occupancy_o, 0);
    chk("rst_push_ready", push_ready_o, 1);
    tick();
    chk("credit_after_beat", credit_valid_o, 0);

    for (int i = 0; i < DEPTH; i++) push(32'h100 + i);
    chk("full_occupancy", occupancy_o, 16);
    chk("full_push_ready", push_ready_o, 0);
    read(3, 0);
    chk("read3_valid", read_data_valid_o, 1);
    chk("read3_data", read_data_o, 32'h103);
    read(15, 0);
    chk("read15_data", read_data_o, 32'h10F);

    shrink(3);
    chk("shrink3_occupancy", occupancy_o, 13);
    chk("shrink3_no_credit", credit_valid_o, 0);
    shrink(1);
    chk("shrink1_credit_valid", credit_valid_o, 1);
    chk("shrink1_credit", credit_o, 4);
    idle(); push_valid_i = 1; push_data_i = 32'h200;
    read_valid_i = 1; read_is_shrink_i = 1; read_idx_i = 2; tick();
    chk("push_shrink_occupancy", occupancy_o, 11);
    shrink(11);
    chk("drained_occupancy", occupancy_o, 0);

    do_reset(); tick();
    push(32'h300); push(32'h301);
    for (int k = 0; k < 4; k++) begin
      idle(); read_valid_i = 1; read_idx_i = 5; push_valid_i = 1; push_data_i = 32'h302 + k;
      #1 chk("fill_stall", read_ready_o, 0);
      tick();
    end
    read(5, 0);
    chk("fill_read_data", read_data_o, 32'h305);

    read(1, 1);
    chk("lock_taken", update_ready_o, 1);
    idle(); read_valid_i = 1; read_idx_i = 1;
    update_valid_i = 1; update_idx_i = 1; update_data_i = 32'hAA; tick();
    chk("raw_stall_no_resp", read_data_valid_o, 0);
    read(1, 0);
    chk("raw_read_new_data", read_data_o, 32'hAA);
    chk("err_clean", err_o, 0);
    read(0, 1);
    update(2, 32'hBB);
    chk("err_wrong_idx", err_o, 1);

    do_reset(); tick();
    for (int i = 0; i < DEPTH; i++) push(32'h400 + i);
    cr_default = 0;
    shrink(15); shrink(1);
    chk("wrap_credit_valid", credit_valid_o, 1);
    chk("wrap_credit", credit_o, 16);
    cr_default = 1;
    for (int i = 0; i < 4; i++) push(32'h410 + i);
    chk("wrap_occupancy", occupancy_o, 4);
    read(0, 0);
    chk("wrap_read_data", read_data_o, 32'h410);

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset_i            = ($urandom_range(0, 299) == 0);
      push_valid_i       = ($urandom_range(0, 9) < 6);
      push_data_i        = $urandom;
      read_valid_i       = ($urandom_range(0, 9) < 6);
      read_is_shrink_i   = ($urandom_range(0, 3) == 0);
      read_will_update_i = ($urandom_range(0, 4) == 0);
      if (read_is_shrink_i)                  read_idx_i = IW'($urandom_range(0, 4));
      else if (q.size() > 0 && $urandom_range(0, 3) != 0)
                                             read_idx_i = IW'($urandom_range(0, q.size() - 1));
      else                                   read_idx_i = IW'($urandom_range(0, 15));
      read_data_ready_i  = ($urandom_range(0, 9) < 7);
      update_valid_i     = ($urandom_range(0, 9) < 4);
      update_data_i      = $urandom;
      if (m_lv && $urandom_range(0, 49) != 0) update_idx_i = IW'(m_li);
      else if (q.size() > 0)                  update_idx_i = IW'($urandom_range(0, q.size() - 1));
      else                                    update_idx_i = IW'(m_li);
      credit_ready_i     = $urandom_range(0, 1);
      tick();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
